// File: rtl/floor_scroll.sv
// Scrolling floor manager: eight floor slots drift down while the slime is
// pinned at the ceiling, and fall off at the bottom to be respawned at the top.

module floor_slot #(
    parameter logic [9:0] X_RST = 10'd0,
    parameter logic [9:0] Y_RST = 10'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       spawn,
    input  logic [9:0] spawn_x,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       en
);
    // A live slot only scrolls or retires; only a free slot can take a spawn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x  <= X_RST;
            y  <= Y_RST;
            en <= 1'b1;
        end else if (en && step) begin
            if (y < 10'd479) y <= y + 10'd1;
            else             en <= 1'b0;
        end else if (!en && spawn) begin
            x  <= spawn_x;
            y  <= 10'd0;
            en <= 1'b1;
        end
    end
endmodule

module floor_scroll (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_vga,
    input  logic        hit_ceiling,
    input  logic [8:0]  time_gap,
    input  logic        slime_die,
    output logic [9:0]  floor_pos_x0,
    output logic [9:0]  floor_pos_x1,
    output logic [9:0]  floor_pos_x2,
    output logic [9:0]  floor_pos_x3,
    output logic [9:0]  floor_pos_x4,
    output logic [9:0]  floor_pos_x5,
    output logic [9:0]  floor_pos_x6,
    output logic [9:0]  floor_pos_x7,
    output logic [9:0]  floor_pos_y0,
    output logic [9:0]  floor_pos_y1,
    output logic [9:0]  floor_pos_y2,
    output logic [9:0]  floor_pos_y3,
    output logic [9:0]  floor_pos_y4,
    output logic [9:0]  floor_pos_y5,
    output logic [9:0]  floor_pos_y6,
    output logic [9:0]  floor_pos_y7,
    output logic [7:0]  enable,
    output logic [15:0] score
);
    localparam int NUM_SLOTS = 8;
    localparam logic [NUM_SLOTS-1:0][9:0] X_RST = {
        10'd160, 10'd360, 10'd40, 10'd520, 10'd200, 10'd450, 10'd100, 10'd300
    };

    logic [15:0]                 lfsr;
    logic [6:0]                  gap_cnt;
    logic                        rate_ok, step, spawn;
    logic [9:0]                  lfsr_lo, spawn_x;
    logic [NUM_SLOTS-1:0]        spawn_sel;
    logic [NUM_SLOTS-1:0][9:0]   pos_x, pos_y;

    // Scroll rate slows as the jump phase advances; out-of-range phases never scroll.
    always_comb begin
        rate_ok = 1'b0;
        if (time_gap >= 9'd1 && time_gap <= 9'd79)
            rate_ok = 1'b1;
        else if (time_gap >= 9'd80 && time_gap <= 9'd159)
            rate_ok = ~time_gap[0];
        else if (time_gap >= 9'd160 && time_gap <= 9'd239)
            rate_ok = (time_gap[1:0] == 2'b00);
        else if (time_gap >= 9'd240 && time_gap <= 9'd319)
            rate_ok = (time_gap[2:0] == 3'b000);
    end

    assign step      = clk_vga && hit_ceiling && !slime_die && rate_ok;
    assign spawn     = clk_vga && !slime_die && (gap_cnt == 7'd60) && !(&enable);
    assign spawn_sel = ~enable & (enable + 8'd1);
    assign lfsr_lo   = lfsr[9:0];
    assign spawn_x   = (lfsr_lo < 10'd580) ? lfsr_lo : lfsr_lo - 10'd580;

    // Free-running LFSR keeps shifting even while the game is frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= 7'd40;
            score   <= 16'd0;
        end else begin
            if (spawn)
                gap_cnt <= 7'd0;
            else if (step && gap_cnt != 7'd60)
                gap_cnt <= gap_cnt + 7'd1;
            if (step && score != 16'hFFFF)
                score <= score + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        floor_slot #(
            .X_RST(X_RST[i]),
            .Y_RST(10'(440 - 60 * i))
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .step    (step),
            .spawn   (spawn && spawn_sel[i]),
            .spawn_x (spawn_x),
            .x       (pos_x[i]),
            .y       (pos_y[i]),
            .en      (enable[i])
        );
    end

    assign floor_pos_x0 = pos_x[0];
    assign floor_pos_x1 = pos_x[1];
    assign floor_pos_x2 = pos_x[2];
    assign floor_pos_x3 = pos_x[3];
    assign floor_pos_x4 = pos_x[4];
    assign floor_pos_x5 = pos_x[5];
    assign floor_pos_x6 = pos_x[6];
    assign floor_pos_x7 = pos_x[7];
    assign floor_pos_y0 = pos_y[0];
    assign floor_pos_y1 = pos_y[1];
    assign floor_pos_y2 = pos_y[2];
    assign floor_pos_y3 = pos_y[3];
    assign floor_pos_y4 = pos_y[4];
    assign floor_pos_y5 = pos_y[5];
    assign floor_pos_y6 = pos_y[6];
    assign floor_pos_y7 = pos_y[7];
endmodule
